// File: rtl/ntt_ctl_pkg.sv
// Shared definitions for the NTT butterfly sequencer and its datapath.
package ntt_ctl_pkg;

   localparam int unsigned DEF_LOGN    = 8;
   localparam int unsigned DEF_BFU_LAT = 8;
   localparam int unsigned DEF_RD_LAT  = 1;

   localparam logic MODE_NTT  = 1'b0;
   localparam logic MODE_INTT = 1'b1;

   // Modulus-select encodings understood by the butterfly.
   localparam logic [1:0] QSEL_0 = 2'd0;
   localparam logic [1:0] QSEL_1 = 2'd1;
   localparam logic [1:0] QSEL_2 = 2'd2;
   localparam logic [1:0] QSEL_3 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_FIN
   } state_e;

endpackage

// File: rtl/ntt_wb_delay.sv
// Fixed-depth shift register with asynchronous active-low clear.
module ntt_wb_delay #(
   parameter int unsigned DEPTH = 9,
   parameter int unsigned WIDTH = 17
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sr_q [DEPTH];

   // Shift one entry per clock; clear the whole line on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= d_i;
         for (int unsigned i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/ntt_bfu_ctl.sv
// Stage/butterfly sequencer for the NTT/INTT butterfly unit and coefficient RAM.
module ntt_bfu_ctl
   import ntt_ctl_pkg::*;
#(
   parameter int unsigned LOGN    = DEF_LOGN,
   parameter int unsigned BFU_LAT = DEF_BFU_LAT,
   parameter int unsigned RD_LAT  = DEF_RD_LAT
) (
   input  logic            iSYS_CLK,
   input  logic            iSYS_RST,
   input  logic            iFSM_START,
   input  logic            iCTL_SEL,
   input  logic [1:0]      iCTL_Q,
   output logic            oBUSY,
   output logic            oDONE,
   output logic            oBFU_EN,
   output logic            oBFU_SEL,
   output logic [1:0]      oBFU_Q,
   output logic            oRD_EN,
   output logic [LOGN-1:0] oRD_ADDR_A,
   output logic [LOGN-1:0] oRD_ADDR_B,
   output logic [LOGN:0]   oW_ADDR,
   output logic            oWR_EN,
   output logic [LOGN-1:0] oWR_ADDR_A,
   output logic [LOGN-1:0] oWR_ADDR_B
);

   localparam int unsigned NHALF = 1 << (LOGN - 1);
   localparam int unsigned DLY   = RD_LAT + BFU_LAT;
   localparam int unsigned KW    = LOGN - 1;
   localparam int unsigned SW    = (LOGN > 2) ? $clog2(LOGN) : 1;
   localparam int unsigned DW    = (DLY > 2) ? $clog2(DLY) : 1;
   localparam int unsigned WBW   = 1 + 2 * LOGN;

   state_e          state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [KW-1:0]   k_q, k_d;
   logic [DW-1:0]   dcnt_q, dcnt_d;
   logic            mode_q, mode_d;
   logic [1:0]      qsel_q, qsel_d;

   logic [SW-1:0]   lsh;
   logic [LOGN-1:0] kx, len, grp, ofs, rda, rdb, idx;
   logic            rd_en_d;
   logic [WBW-1:0]  wb_q;

   // Next state and counters; everything downstream is computed for the
   // upcoming cycle so that all outputs can be registered.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      k_d     = k_q;
      dcnt_d  = dcnt_q;
      mode_d  = mode_q;
      qsel_d  = qsel_q;
      case (state_q)
         ST_IDLE: begin
            if (iFSM_START) begin
               state_d = ST_RUN;
               s_d     = '0;
               k_d     = '0;
               mode_d  = iCTL_SEL;
               qsel_d  = iCTL_Q;
            end
         end
         ST_RUN: begin
            if (k_q == KW'(NHALF - 1)) begin
               state_d = ST_DRAIN;
               dcnt_d  = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (dcnt_q == DW'(DLY - 1)) begin
               if (s_q == SW'(LOGN - 1)) begin
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_RUN;
                  s_d     = s_q + 1'b1;
                  k_d     = '0;
               end
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Butterfly pair and twiddle index: len is a power of two, so the
   // group/offset split of k is a shift and a mask.
   always_comb begin
      lsh     = (mode_d == MODE_NTT) ? (SW'(LOGN - 1) - s_d) : s_d;
      kx      = {1'b0, k_d};
      len     = LOGN'(1) << lsh;
      grp     = kx >> lsh;
      ofs     = kx & (len - 1'b1);
      rda     = ((grp << lsh) << 1) | ofs;
      rdb     = rda + len;
      idx     = (LOGN'(NHALF) >> lsh) + grp;
      rd_en_d = (state_d == ST_RUN);
   end

   // State, counters, latched controls and registered outputs.
   always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
      if (!iSYS_RST) begin
         state_q    <= ST_IDLE;
         s_q        <= '0;
         k_q        <= '0;
         dcnt_q     <= '0;
         mode_q     <= '0;
         qsel_q     <= '0;
         oBUSY      <= '0;
         oDONE      <= '0;
         oBFU_EN    <= '0;
         oBFU_SEL   <= '0;
         oBFU_Q     <= '0;
         oRD_EN     <= '0;
         oRD_ADDR_A <= '0;
         oRD_ADDR_B <= '0;
         oW_ADDR    <= '0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         k_q        <= k_d;
         dcnt_q     <= dcnt_d;
         mode_q     <= mode_d;
         qsel_q     <= qsel_d;
         oBUSY      <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
         oBFU_EN    <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
         oDONE      <= (state_d == ST_FIN);
         oBFU_SEL   <= mode_d;
         oBFU_Q     <= qsel_d;
         oRD_EN     <= rd_en_d;
         oRD_ADDR_A <= rd_en_d ? rda : '0;
         oRD_ADDR_B <= rd_en_d ? rdb : '0;
         oW_ADDR    <= rd_en_d ? {mode_d, idx} : '0;
      end
   end

   // The registered read strobe/addresses enter the line, so a depth of
   // RD_LAT+BFU_LAT lands each write exactly that many cycles after its read.
   ntt_wb_delay #(
      .DEPTH (DLY),
      .WIDTH (WBW)
   ) u_wb_delay (
      .clk_i  (iSYS_CLK),
      .rst_ni (iSYS_RST),
      .d_i    ({oRD_EN, oRD_ADDR_A, oRD_ADDR_B}),
      .q_o    (wb_q)
   );

   assign oWR_EN     = wb_q[2*LOGN];
   assign oWR_ADDR_A = wb_q[2*LOGN-1:LOGN];
   assign oWR_ADDR_B = wb_q[LOGN-1:0];

endmodule
